// File: rtl/avalon_mem_slave.sv
// Avalon-MM slave RAM with fixed or LFSR-driven wait states.
// Unified instruction+data memory for bus-level simulation of the CPU master.
module avalon_mem_slave #(
    parameter int          ADDR_BITS   = 10,
    parameter              INIT_FILE   = "",
    parameter bit          RAND_WAIT   = 1'b0,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [3:0]  WAIT_MASK   = 4'hF,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        protocol_err
);
    localparam int         DEPTH      = 1 << ADDR_BITS;
    localparam logic [3:0] FIXED_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state_reg;
    logic [3:0]             cnt_reg;
    logic [15:0]            lfsr_reg;
    logic [31:0]            readdata_reg;
    logic                   protocol_err_reg;
    logic [31:0]            mem [DEPTH];

    logic                   req;
    logic                   accept;
    logic [3:0]             wait_w;
    logic [ADDR_BITS-1:0]   idx;
    logic                   lfsr_fb;
    logic                   unused_addr;

    assign req         = read | write;
    assign wait_w      = RAND_WAIT ? (lfsr_reg[3:0] & WAIT_MASK) : FIXED_WAIT;
    assign idx         = address[ADDR_BITS+1:2];
    assign unused_addr = ^{address[31:ADDR_BITS+2], address[1:0]};
    // Fibonacci taps 16,14,13,11
    assign lfsr_fb     = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    assign readdata     = readdata_reg;
    assign protocol_err = protocol_err_reg;

    // Stall depends only on control state so the master sees no path from address/data.
    always_comb begin
        waitrequest = 1'b1;
        if (reset) begin
            if (state_reg == IDLE) begin
                waitrequest = req && (wait_w != 4'd0);
            end else begin
                waitrequest = req && (cnt_reg != 4'd0);
            end
        end
    end

    assign accept = reset & req & ~waitrequest;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            lfsr_reg         <= LFSR_SEED;
            readdata_reg     <= 32'd0;
            protocol_err_reg <= 1'b0;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
            case (state_reg)
                IDLE: begin
                    if (req && (wait_w != 4'd0)) begin
                        cnt_reg   <= wait_w - 4'd1;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        // master dropped the request mid-stall
                        protocol_err_reg <= 1'b1;
                        cnt_reg          <= 4'd0;
                        state_reg        <= IDLE;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (accept) begin
                if (read && write) begin
                    protocol_err_reg <= 1'b1;
                end else if (read) begin
                    readdata_reg <= mem[idx];
                end
            end
        end
    end

    // Memory has no reset so it maps onto block RAM with byte-write enables.
    always_ff @(posedge clk) begin
        if (accept && write) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem[idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_avalon_mem_slave.sv
// Directed bench: four slave instances (wait 0, 3, 5, random/mask 7) share one bus, gated by sel.
module tb_avalon_mem_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    int          sel;

    logic [3:0]  rd_v;
    logic [3:0]  wr_v;
    logic [3:0]  waitreq;
    logic [3:0]  perr;
    logic [31:0] rdata [4];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [16];
    int          stall;
    bit          saw_zero;
    bit          saw_stall;
    bit          found;
    int          ridx;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sel
        assign rd_v[gi] = read  && (sel == gi);
        assign wr_v[gi] = write && (sel == gi);
    end

    avalon_mem_slave #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .read(rd_v[0]), .write(wr_v[0]), .address(address),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(waitreq[0]),
        .readdata(rdata[0]), .protocol_err(perr[0]));

    avalon_mem_slave #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .read(rd_v[1]), .write(wr_v[1]), .address(address),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(waitreq[1]),
        .readdata(rdata[1]), .protocol_err(perr[1]));

    avalon_mem_slave #(.WAIT_CYCLES(5)) u_w5 (
        .clk(clk), .reset(reset), .read(rd_v[2]), .write(wr_v[2]), .address(address),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(waitreq[2]),
        .readdata(rdata[2]), .protocol_err(perr[2]));

    avalon_mem_slave #(.RAND_WAIT(1'b1), .WAIT_MASK(4'h7)) u_rnd (
        .clk(clk), .reset(reset), .read(rd_v[3]), .write(wr_v[3]), .address(address),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(waitreq[3]),
        .readdata(rdata[3]), .protocol_err(perr[3]));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(int k, bit r, bit w, logic [31:0] a, logic [3:0] be, logic [31:0] d);
        @(negedge clk);
        sel = k; read = r; write = w; address = a; byteenable = be; writedata = d;
    endtask

    task automatic idle();
        @(negedge clk);
        read = 1'b0; write = 1'b0;
    endtask

    // zero-wait access: must be accepted in the cycle it is presented
    task automatic step(int k, bit r, bit w, logic [31:0] a, logic [3:0] be, logic [31:0] d, string tag);
        drive(k, r, w, a, be, d);
        #1 chk(tag, waitreq[k], 0);
        @(posedge clk); #1;
    endtask

    // fixed-wait access: waitrequest high for exactly n cycles, then low
    task automatic xfer_fixed(int k, bit r, bit w, logic [31:0] a, logic [31:0] d, int n, string tag);
        drive(k, r, w, a, 4'hF, d);
        #1;
        for (int c = 0; c <= n; c++) begin
            chk(tag, waitreq[k], (c < n));
            @(posedge clk); #1;
        end
        idle();
    endtask

    // master drops the request after two stalled cycles
    task automatic abandon(int k, bit r, bit w, logic [31:0] a, logic [31:0] d, string tag);
        drive(k, r, w, a, 4'hF, d);
        #1 chk({tag, "_stall0"}, waitreq[k], 1);
        @(posedge clk); #1 chk({tag, "_stall1"}, waitreq[k], 1);
        @(negedge clk); read = 1'b0; write = 1'b0;
        #1 chk({tag, "_dropped_wr"}, waitreq[k], 0);
        @(posedge clk); #1 chk({tag, "_perr"}, perr[k], 1);
    endtask

    task automatic xfer_rand(bit r, bit w, logic [31:0] a, logic [31:0] d, output int n);
        drive(3, r, w, a, 4'hF, d);
        n = 0;
        #1;
        while (waitreq[3] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rand_stall_bound", (n <= 7), 1);
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        reset = 1'b0; read = 1'b0; write = 1'b0; sel = 0;
        address = 32'd0; byteenable = 4'd0; writedata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 4; i++)
            step(0, 1'b0, 1'b1, 32'hBFC0_0000 + 32'(4 * i), 4'hF, 32'h1111_1111 * 32'(i + 1), "preload_wait");

        // reset held with read pending: stall everywhere, outputs cleared, memory kept
        @(negedge clk);
        reset = 1'b0; sel = 0; read = 1'b1; write = 1'b0; address = 32'hBFC0_0000;
        for (int c = 0; c < 2; c++) begin
            #1 chk("rst_waitreq", waitreq, 4'hF);
            @(posedge clk);
            #1 chk("rst_readdata", rdata[0], 32'h0);
            chk("rst_perr", perr, 4'h0);
            @(negedge clk);
        end
        reset = 1'b1;
        #1 chk("rst_release_wait", waitreq[0], 0);
        @(posedge clk); #1 chk("stream_rd0", rdata[0], 32'h1111_1111);
        step(0, 1'b1, 1'b0, 32'hBFC0_0004, 4'h0, 32'h0, "stream_wait1");
        chk("stream_rd1", rdata[0], 32'h2222_2222);
        step(0, 1'b1, 1'b0, 32'hBFC0_0008, 4'h0, 32'h0, "stream_wait2");
        chk("stream_rd2", rdata[0], 32'h3333_3333);
        step(0, 1'b1, 1'b0, 32'hBFC0_000C, 4'h0, 32'h0, "stream_wait3");
        chk("stream_rd3", rdata[0], 32'h4444_4444);

        // read-after-write on consecutive cycles
        step(0, 1'b0, 1'b1, 32'h0000_0014, 4'hF, 32'h0000_A5A5, "raw_wr_wait");
        step(0, 1'b1, 1'b0, 32'h0000_0014, 4'h0, 32'h0, "raw_rd_wait");
        chk("raw_data", rdata[0], 32'h0000_A5A5);

        // byte lanes
        step(0, 1'b0, 1'b1, 32'h0000_0020, 4'hF, 32'hAABB_CCDD, "be_wr_full");
        step(0, 1'b0, 1'b1, 32'h0000_0020, 4'b0100, 32'h00EE_0000, "be_wr_lane2");
        step(0, 1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0, "be_rd");
        chk("be_merge", rdata[0], 32'hAAEE_CCDD);
        step(0, 1'b0, 1'b1, 32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, "be_wr_none");
        chk("wr_keeps_readdata", rdata[0], 32'hAAEE_CCDD);
        step(0, 1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0, "be_rd2");
        chk("be_none_unchanged", rdata[0], 32'hAAEE_CCDD);

        // simultaneous read+write: write wins, readdata held, error flagged
        chk("perr_before_rw", perr[0], 0);
        step(0, 1'b1, 1'b1, 32'h0000_0024, 4'hF, 32'h1234_5678, "rw_wait");
        chk("rw_readdata_held", rdata[0], 32'hAAEE_CCDD);
        chk("rw_perr", perr[0], 1);
        step(0, 1'b1, 1'b0, 32'h0000_0024, 4'h0, 32'h0, "rw_rd");
        chk("rw_written", rdata[0], 32'h1234_5678);
        idle();

        // fixed wait of 3
        xfer_fixed(1, 1'b0, 1'b1, 32'h0000_0010, 32'h5A5A_0003, 3, "w3_wr_wait");
        chk("w3_rd_before", rdata[1], 32'h0);
        xfer_fixed(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, "w3_rd_wait");
        chk("w3_rd_data", rdata[1], 32'h5A5A_0003);
        chk("w3_perr", perr[1], 0);

        // fixed wait of 5 with abandoned transfers
        xfer_fixed(2, 1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 5, "w5_wr_wait");
        chk("w5_perr_clean", perr[2], 0);
        abandon(2, 1'b1, 1'b0, 32'h0000_0030, 32'h0, "w5_abort_rd");
        chk("w5_abort_rd_nodata", rdata[2], 32'h0);
        abandon(2, 1'b0, 1'b1, 32'h0000_0030, 32'hDEAD_BEEF, "w5_abort_wr");
        xfer_fixed(2, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 5, "w5_rd_after_abort");
        chk("w5_mem_unchanged", rdata[2], 32'h0BAD_F00D);

        // random waits, mask 7
        saw_zero = 1'b0; saw_stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            xfer_rand(1'b0, 1'b1, 32'h2000_0000 + 32'(4 * i), model[i], stall);
            if (stall == 0) saw_zero = 1'b1; else saw_stall = 1'b1;
        end
        for (int i = 0; i < 200; i++) begin
            ridx = $urandom_range(0, 15);
            xfer_rand(1'b1, 1'b0, 32'h1000_0000 + 32'(4 * ridx), 32'h0, stall);
            if (stall == 0) saw_zero = 1'b1; else saw_stall = 1'b1;
            chk("rand_rd_data", rdata[3], model[ridx]);
        end
        chk("rand_saw_zero", saw_zero, 1);
        chk("rand_saw_stall", saw_stall, 1);

        // reset while stalled, then a clean read
        found = 1'b0;
        for (int a = 0; a < 50 && !found; a++) begin
            drive(3, 1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0);
            #1;
            if (waitreq[3]) found = 1'b1;
            @(posedge clk); #1;
        end
        chk("midwait_found", found, 1);
        @(negedge clk); reset = 1'b0; read = 1'b0;
        @(posedge clk); #1 chk("midwait_rst_readdata", rdata[3], 32'h0);
        chk("midwait_rst_perr", perr[3], 0);
        @(negedge clk); reset = 1'b1;
        xfer_rand(1'b1, 1'b0, 32'h0000_0008, 32'h0, stall);
        chk("midwait_rd_data", rdata[3], model[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
